// File: rtl/uart_sram_bridge_pkg.sv
// Shared opcodes, FSM encodings and small helpers for the UART-to-SRAM command bridge.
package uart_sram_bridge_pkg;

  localparam logic [7:0] OP_SET_ADDR   = 8'h01;
  localparam logic [7:0] OP_WRITE      = 8'h02;
  localparam logic [7:0] OP_READ       = 8'h03;
  localparam logic [7:0] OP_SET_LEN    = 8'h04;
  localparam logic [7:0] OP_BURST_READ = 8'h05;
  localparam logic [7:0] OP_STATUS     = 8'h06;

  typedef enum logic [2:0] {
    ST_RX,
    ST_EXEC,
    ST_MEM_REQ,
    ST_MEM_WAIT_LO,
    ST_MEM_WAIT_HI,
    ST_TX_SEND,
    ST_TX_WAIT
  } bridge_state_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_WAIT_LO,
    SER_WAIT_HI
  } ser_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_sram_bridge_resp_serialiser.sv
// Shifts a RESP_BYTES response word out MSB byte first over the UART TX handshake,
// pulsing done once the last byte's transmission has completed.
module uart_sram_bridge_resp_serialiser
  import uart_sram_bridge_pkg::*;
#(
  parameter int RESP_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [8*RESP_BYTES-1:0] word,
  input  logic                    tx_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  output logic                    done
);

  localparam int RESP_W = 8 * RESP_BYTES;
  localparam int CNT_W  = $clog2(RESP_BYTES + 1);

  ser_state_e        state_q, state_d;
  logic [RESP_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SER_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    tx_start = 1'b0;
    done     = 1'b0;
    tx_data  = shreg_q[RESP_W-1 -: 8];
    case (state_q)
      SER_IDLE: begin
        if (load) begin
          shreg_d = word;
          cnt_d   = '0;
          state_d = SER_SEND;
        end
      end
      SER_SEND: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          state_d  = SER_WAIT_LO;
        end
      end
      SER_WAIT_LO: begin
        if (!tx_ready) state_d = SER_WAIT_HI;
      end
      SER_WAIT_HI: begin
        // A byte only counts as sent once the UART has gone busy and returned to idle.
        if (tx_ready) begin
          if (cnt_q == CNT_W'(RESP_BYTES - 1)) begin
            done    = 1'b1;
            state_d = SER_IDLE;
          end else begin
            shreg_d = shreg_q << 8;
            cnt_d   = cnt_q + 1'b1;
            state_d = SER_SEND;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_sram_bridge.sv
// Parses fixed-length UART command frames into SRAM single/burst accesses and queues
// the RESP_BYTES-wide responses through the serialiser.
module uart_sram_bridge
  import uart_sram_bridge_pkg::*;
#(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int ARG_BYTES  = 4,
  parameter int RESP_BYTES = 4,
  parameter int LEN_W      = 16,
  parameter int RX_TIMEOUT = 1200000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              mem_ready,
  output logic              mem_start,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [7:0]        overruns
);

  localparam int ARG_W   = 8 * ARG_BYTES;
  localparam int RESP_W  = 8 * RESP_BYTES;
  localparam int FRAME_W = ARG_W + 8;
  localparam int BCNT_W  = $clog2(ARG_BYTES + 2);
  localparam int TMO_W   = $clog2(RX_TIMEOUT + 1);

  bridge_state_e     state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_re_q, mem_re_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [7:0]        ovr_q, ovr_d;
  logic              ser_load, ser_done;
  logic [7:0]        opcode;
  logic [ARG_W-1:0]  arg;

  assign opcode    = frame_q[FRAME_W-1 -: 8];
  assign arg       = frame_q[ARG_W-1:0];
  assign mem_start = (state_q == ST_MEM_REQ) && mem_ready;
  assign mem_re    = mem_re_q;
  assign mem_addr  = ptr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_RX);
  assign overruns  = ovr_q;
  assign ser_load  = (state_q == ST_TX_SEND);

  uart_sram_bridge_resp_serialiser #(
    .RESP_BYTES(RESP_BYTES)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .load    (ser_load),
    .word    (resp_q),
    .tx_ready(tx_ready),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .done    (ser_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RX;
      frame_q  <= '0;
      bcnt_q   <= '0;
      tmo_q    <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      wdata_q  <= '0;
      mem_re_q <= 1'b0;
      resp_q   <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      bcnt_q   <= bcnt_d;
      tmo_q    <= tmo_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      wdata_q  <= wdata_d;
      mem_re_q <= mem_re_d;
      resp_q   <= resp_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bcnt_d   = bcnt_q;
    tmo_d    = tmo_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    rem_d    = rem_q;
    wdata_d  = wdata_q;
    mem_re_d = mem_re_q;
    resp_d   = resp_q;
    ovr_d    = ovr_q;

    if (rx_valid && state_q != ST_RX) ovr_d = sat_inc8(ovr_q);

    case (state_q)
      ST_RX: begin
        if (rx_valid) begin
          frame_d = {frame_q[FRAME_W-9:0], rx_data};
          tmo_d   = '0;
          if (bcnt_q == BCNT_W'(ARG_BYTES)) begin
            bcnt_d  = '0;
            state_d = ST_EXEC;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else if (bcnt_q != '0) begin
          // A stalled partial frame is discarded so the next byte starts a fresh frame.
          if (tmo_q == TMO_W'(RX_TIMEOUT - 1)) begin
            bcnt_d = '0;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_TX_SEND;
        resp_d  = '0;
        rem_d   = '0;
        case (opcode)
          OP_SET_ADDR: begin
            ptr_d  = arg[ADDR_W-1:0];
            resp_d = RESP_W'(arg);
          end
          OP_WRITE: begin
            wdata_d  = arg[DATA_W-1:0];
            mem_re_d = 1'b0;
            state_d  = ST_MEM_REQ;
          end
          OP_READ: begin
            mem_re_d = 1'b1;
            rem_d    = LEN_W'(1);
            state_d  = ST_MEM_REQ;
          end
          OP_SET_LEN: begin
            len_d  = arg[LEN_W-1:0];
            resp_d = RESP_W'(arg);
          end
          OP_BURST_READ: begin
            if (len_q != '0) begin
              mem_re_d = 1'b1;
              rem_d    = len_q;
              state_d  = ST_MEM_REQ;
            end
          end
          OP_STATUS: resp_d = RESP_W'({ovr_q, ptr_q});
          default:   resp_d = '1;
        endcase
      end
      ST_MEM_REQ: begin
        if (mem_ready) state_d = ST_MEM_WAIT_LO;
      end
      ST_MEM_WAIT_LO: begin
        if (!mem_ready) state_d = ST_MEM_WAIT_HI;
      end
      ST_MEM_WAIT_HI: begin
        if (mem_ready) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = ST_TX_SEND;
          if (mem_re_q) begin
            resp_d = RESP_W'(mem_rdata);
            rem_d  = rem_q - LEN_W'(1);
          end
        end
      end
      ST_TX_SEND: state_d = ST_TX_WAIT;
      ST_TX_WAIT: begin
        // Remaining burst words loop back to memory after each response drains.
        if (ser_done) state_d = (rem_q != '0) ? ST_MEM_REQ : ST_RX;
      end
      default: state_d = ST_RX;
    endcase
  end

endmodule

// File: tb/tb_uart_sram_bridge.sv
// Scoreboard bench for uart_sram_bridge: a high-level command model predicts response words,
// and UART/SRAM responder processes compare what the bridge actually transmits.
module tb_uart_sram_bridge;

  localparam int TB_TIMEOUT = 40;
  localparam int ADDR_SPAN  = 8192;
  localparam int IDLE_LIMIT = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        mem_ready;
  logic        mem_start;
  logic        mem_re;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [7:0]  overruns;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_start_cnt = 0;
  int resp_cnt = 0;
  int asm_cnt  = 0;
  logic [31:0] asm_word;
  logic [31:0] exp_q[$];

  logic [7:0] sram_mem[ADDR_SPAN];
  logic [7:0] ref_mem[ADDR_SPAN];
  int model_ptr = 0;
  int model_len = 0;
  int model_ovr = 0;

  uart_sram_bridge #(
    .RX_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .mem_ready(mem_ready),
    .mem_start(mem_start),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .overruns (overruns)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Behavioural command model: predicts response words and the number of SRAM accesses.
  task automatic modelCommand(input logic [7:0] op, input logic [31:0] arg, output int n_acc);
    n_acc = 0;
    case (op)
      8'h01: begin model_ptr = int'(arg % ADDR_SPAN); exp_q.push_back(arg); end
      8'h02: begin
        ref_mem[model_ptr] = arg[7:0];
        model_ptr = (model_ptr + 1) % ADDR_SPAN;
        exp_q.push_back(32'd0);
        n_acc = 1;
      end
      8'h03: begin
        exp_q.push_back({24'd0, ref_mem[model_ptr]});
        model_ptr = (model_ptr + 1) % ADDR_SPAN;
        n_acc = 1;
      end
      8'h04: begin model_len = int'(arg % 65536); exp_q.push_back(arg); end
      8'h05: begin
        if (model_len == 0) exp_q.push_back(32'd0);
        for (int i = 0; i < model_len; i++) begin
          exp_q.push_back({24'd0, ref_mem[model_ptr]});
          model_ptr = (model_ptr + 1) % ADDR_SPAN;
        end
        n_acc = model_len;
      end
      8'h06: exp_q.push_back(32'(model_ovr * ADDR_SPAN + model_ptr));
      default: exp_q.push_back(32'hFFFF_FFFF);
    endcase
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy || exp_q.size() != 0 || !tx_ready || !mem_ready) && n < IDLE_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_within_budget", 32'(n >= IDLE_LIMIT), 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] arg, input bit wait_done);
    int n_acc;
    int start_cnt;
    start_cnt = mem_start_cnt;
    modelCommand(op, arg, n_acc);
    sendByte(op);
    for (int i = 3; i >= 0; i--) sendByte(arg[8*i +: 8]);
    if (wait_done) begin
      waitIdle();
      checkOutput("mem_access_count", 32'(mem_start_cnt - start_cnt), 32'(n_acc));
    end
  endtask

  task automatic injectOverrun(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    model_ovr = (model_ovr + n > 255) ? 255 : model_ovr + n;
  endtask

  // UART TX side: collects bytes into words and pops the scoreboard.
  initial begin : tx_monitor
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start && !reset) begin
        asm_word = {asm_word[23:0], tx_data};
        asm_cnt++;
        if (asm_cnt == 4) begin
          asm_cnt = 0;
          resp_cnt++;
          checkOutput("resp_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) checkOutput("resp_word", asm_word, exp_q.pop_front());
        end
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // SRAM driver model with random access latency.
  initial begin : sram_model
    logic        cap_re;
    logic [12:0] cap_addr;
    logic [7:0]  cap_wdata;
    mem_ready = 1'b1;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_start && !reset) begin
        mem_start_cnt++;
        cap_re    = mem_re;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        if (cap_re) mem_rdata = sram_mem[cap_addr];
        else sram_mem[cap_addr] = cap_wdata;
        #1 mem_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int start_cnt;
    int start_resp;
    logic [7:0] rop;
    logic [31:0] rarg;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    for (int i = 0; i < ADDR_SPAN; i++) begin
      sram_mem[i] = 8'($urandom);
      ref_mem[i]  = sram_mem[i];
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_tx_start", 32'(tx_start), 32'd0);
    checkOutput("reset_mem_start", 32'(mem_start), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_overruns", 32'(overruns), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] wraparound write/read");
    applyStimulus(8'h01, 32'h0000_1FFE, 1);
    applyStimulus(8'h02, 32'h0000_00A5, 1);
    applyStimulus(8'h02, 32'h0000_005A, 1);
    applyStimulus(8'h01, 32'h0000_1FFE, 1);
    applyStimulus(8'h03, 32'h0, 1);
    applyStimulus(8'h03, 32'h0, 1);
    applyStimulus(8'h06, 32'h0, 1);
    checkOutput("ptr_wrapped", 32'(mem_addr), 32'(model_ptr));

    $display("[TB] burst read of three words");
    applyStimulus(8'h01, 32'h0000_0010, 1);
    applyStimulus(8'h04, 32'h0000_0003, 1);
    applyStimulus(8'h05, 32'h0, 1);
    applyStimulus(8'h06, 32'h0, 1);

    $display("[TB] unknown opcode and empty burst");
    applyStimulus(8'h7F, 32'h1234_5678, 1);
    applyStimulus(8'h04, 32'hABCD_0000, 1);
    applyStimulus(8'h05, 32'h0, 1);

    $display("[TB] partial frame timeout");
    start_resp = resp_cnt;
    sendByte(8'h02);
    sendByte(8'h00);
    sendByte(8'h00);
    repeat (TB_TIMEOUT + 1) @(negedge clk);
    applyStimulus(8'h03, 32'h0, 1);
    checkOutput("timeout_resp_count", 32'(resp_cnt - start_resp), 32'd1);

    $display("[TB] randomized commands");
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 7))
        0: rop = 8'h01;
        1, 7: rop = 8'h02;
        2: rop = 8'h03;
        3: rop = 8'h04;
        4: rop = 8'h05;
        5: rop = 8'h06;
        default: rop = 8'($urandom_range(7, 255));
      endcase
      rarg = $urandom;
      if (rop == 8'h04) rarg[15:0] = 16'($urandom_range(0, 4));
      applyStimulus(rop, rarg, 1);
    end

    $display("[TB] overrun accounting");
    applyStimulus(8'h04, 32'd8, 1);
    start_cnt = mem_start_cnt;
    applyStimulus(8'h05, 32'h0, 0);
    repeat (5) @(negedge clk);
    injectOverrun(4);
    waitIdle();
    checkOutput("burst8_access_count", 32'(mem_start_cnt - start_cnt), 32'd8);
    applyStimulus(8'h06, 32'h0, 1);
    checkOutput("overruns_4", 32'(overruns), 32'(model_ovr));
    applyStimulus(8'h04, 32'd40, 1);
    applyStimulus(8'h05, 32'h0, 0);
    repeat (5) @(negedge clk);
    injectOverrun(300);
    waitIdle();
    applyStimulus(8'h06, 32'h0, 1);
    checkOutput("overruns_saturated", 32'(overruns), 32'd255);

    $display("[TB] reset during burst read");
    applyStimulus(8'h01, 32'h0000_0123, 1);
    applyStimulus(8'h04, 32'd5, 1);
    applyStimulus(8'h05, 32'h0, 0);
    repeat (25) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_tx_start", 32'(tx_start), 32'd0);
    checkOutput("midreset_mem_start", 32'(mem_start), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_ptr", 32'(mem_addr), 32'd0);
    checkOutput("midreset_overruns", 32'(overruns), 32'd0);
    reset = 1'b0;
    model_ptr = 0;
    model_len = 0;
    model_ovr = 0;
    for (int n = 0; n < IDLE_LIMIT && !(tx_ready && mem_ready); n++) @(negedge clk);
    exp_q.delete();
    asm_cnt = 0;
    start_cnt = mem_start_cnt;
    repeat (10) @(negedge clk);
    checkOutput("no_strobe_after_reset", 32'(mem_start_cnt - start_cnt), 32'd0);
    applyStimulus(8'h06, 32'h0, 1);
    applyStimulus(8'h03, 32'h0, 1);

    waitIdle();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
